ccff_bitstream_loader: RTL and testbench
========================================

Name: ccff_bitstream_loader

Overview:
- Drives the configuration-chain head (ccff_head) of a tile chain and observes its tail (ccff_tail).
- Takes bitstream words over a valid/ready stream, serialises them one bit per enabled prog_clk edge and produces a per-cycle chain shift enable.
- Optional verify mode streams the same bitstream a second time and compares the returning tail bits against the bits being shifted in.
- Sits between the programming interface (host/SoC) and the first tile of the ccff chain.

Parameters:
- CHAIN_LEN, 16, number of config flip-flops in the chain (>=1).
- DATA_W, 8, width of input bitstream words (>=1).
- ERR_W, 16, width of the mismatch counter.

Ports:
- prog_clk  input  1  programming clock; all state is on the rising edge.
- pReset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE or DONE.
- verify_en  input  1  sampled with start; 1 = load pass followed by verify pass.
- abort  input  1  synchronous abort; returns the FSM to IDLE.
- s_valid  input  1  bitstream word valid.
- s_data  input  DATA_W  bitstream word; bit 0 is shifted first.
- s_ready  output  1  word accepted when s_valid && s_ready.
- ccff_head  output  1  serial config bit to the chain head, registered.
- chain_en  output  1  registered shift enable; the chain shifts on each prog_clk edge where it is 1.
- ccff_tail  input  1  serial bit from the chain tail.
- busy  output  1  high in LOAD or VERIFY.
- done  output  1  high in DONE.
- error  output  1  sticky verify mismatch flag.
- err_cnt  output  ERR_W  saturating count of verify mismatches.

Behaviour:
- Reset values (asynchronous, pReset=0): state=IDLE; s_ready, ccff_head, chain_en, busy, done, error = 0; err_cnt = 0; all counters and the word buffer = 0.
- FSM states: IDLE, LOAD, VERIFY, DONE.
  - IDLE or DONE + start: clear error and err_cnt, latch verify_en, go to LOAD.
  - LOAD: after CHAIN_LEN enabled bits, go to VERIFY if the latched verify_en is 1, otherwise to DONE.
  - VERIFY: after CHAIN_LEN enabled bits, go to DONE.
  - abort in LOAD or VERIFY: go to IDLE; chain_en = 0 from the next cycle; error and err_cnt are held.
  - start while busy is ignored.
  - abort and start in the same cycle: abort wins.
- Words per pass = ceil(CHAIN_LEN/DATA_W). In the last word of a pass, bits at index >= CHAIN_LEN mod DATA_W (when that value is nonzero) are discarded; they are never driven and never enable a shift.
- Word buffer:
  - s_ready = (state is LOAD or VERIFY) && pass bits remaining > 0 && (buffer empty || buffer is presenting its last valid bit this cycle).
  - With s_valid held high, this gives one bit per cycle with no bubbles.
- Serialisation:
  - Latency: a word accepted on edge N drives its bit 0 on ccff_head with chain_en=1 in cycle N+1.
  - Each following valid bit is driven in the next cycle that has data.
  - chain_en = 1 exactly on cycles where ccff_head carries a valid bitstream bit; otherwise chain_en = 0 and ccff_head = 0.
  - A starved stream produces chain_en=0 gap cycles; the chain never takes extra shifts.
- Bit count: a pass counter counts enabled bits 0..CHAIN_LEN-1 and resets between passes. Exactly CHAIN_LEN enables occur per pass, 2*CHAIN_LEN total with verify.
- Verify comparison:
  - In VERIFY, on each cycle with chain_en=1, compare ccff_tail with ccff_head. Pass-1 bit k reaches the tail exactly when pass-2 bit k is at the head.
  - On a mismatch, set error and increment err_cnt, saturating at 2^ERR_W-1.
  - ccff_tail is ignored outside VERIFY.
- busy = (state is LOAD or VERIFY); done = (state is DONE). done holds until the next start or reset.
- Reset mid-operation: immediate return to reset values; the partially loaded chain contents are not this block's concern.

Test Plan (CHAIN_LEN=16, DATA_W=8, bench models a 16-FF chain clocked on chain_en):
- start, verify_en=0, words 0xA5 then 0x3C, s_valid held high -> ccff_head = 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0 over 16 consecutive chain_en cycles; model chain = 0x3CA5 (bit 0 at the tail end); done=1; s_ready low after the second word.
- start, verify_en=1, stream 0xA5,0x3C,0xA5,0x3C -> 32 chain_en cycles; error=0; err_cnt=0; done=1.
- Same as the previous case with the bench forcing ccff_tail=0 during VERIFY -> error=1; err_cnt=8 (the number of 1 bits in 0x3CA5).
- s_valid dropped for 5 cycles between word 0 and word 1 -> exactly 5 chain_en=0 cycles, still exactly 16 enables in total, model chain = 0x3CA5.
- CHAIN_LEN=12, words 0xFF,0x0A -> 12 enables; bits 4..7 of 0x0A discarded; s_ready not asserted for a third word; done=1.
- pReset asserted at enable 7 of LOAD -> all outputs 0 immediately; after release, a fresh start with 0xA5,0x3C completes normally with done=1.

Source files
------------

// File: rtl/ccff_bitstream_loader.sv
// Bitstream loader for a ccff configuration chain: serialises stream words onto
// ccff_head with a per-bit shift enable, optionally re-streaming to verify the tail.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | shifting the first pass into the chain
// VERIFY | shifting the second pass, comparing ccff_tail against ccff_head
// DONE   | load complete; done held until the next start
module ccff_bitstream_loader #(
  parameter int CHAIN_LEN = 16,
  parameter int DATA_W    = 8,
  parameter int ERR_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify_en,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              chain_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int          CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int          BC_W  = $clog2(DATA_W + 1);
  localparam int unsigned DW_U  = DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_verify;
  logic [DATA_W-1:0]  r_buf;
  logic [BC_W-1:0]    r_buf_cnt;
  logic [CNT_W-1:0]   r_acc_rem;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic               r_head;
  logic               r_chain_en;
  logic               r_error;
  logic [ERR_W-1:0]   r_err_cnt;

  logic               w_busy;
  logic               w_start_go;
  logic               w_abort_go;
  logic               w_pass_end;
  logic               w_ready;
  logic               w_accept;
  logic               w_mismatch;
  logic [BC_W-1:0]    w_word_bits;

  assign w_busy     = (r_state == ST_LOAD) || (r_state == ST_VERIFY);
  assign w_start_go = !w_busy && start && !abort;
  assign w_abort_go = w_busy && abort;
  assign w_pass_end = w_busy && r_chain_en && (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));

  // r_buf_cnt counts bits not yet driven, so zero also covers "presenting last bit"
  assign w_ready  = w_busy && !abort && (r_acc_rem != '0) && (r_buf_cnt == '0);
  assign w_accept = w_ready && s_valid;

  assign w_mismatch = (r_state == ST_VERIFY) && r_chain_en && (ccff_tail != r_head);

  // The final word of a pass only carries the bits still owed to the chain
  always_comb begin
    w_word_bits = BC_W'(DATA_W);
    if (32'(r_acc_rem) < DW_U) begin
      w_word_bits = BC_W'(r_acc_rem);
    end
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_start_go) begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_pass_end) begin
          w_state_nxt = r_verify ? ST_VERIFY : ST_DONE;
        end
      end
      ST_VERIFY: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_pass_end) begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      r_verify   <= 1'b0;
      r_buf      <= '0;
      r_buf_cnt  <= '0;
      r_acc_rem  <= '0;
      r_bit_cnt  <= '0;
      r_head     <= 1'b0;
      r_chain_en <= 1'b0;
      r_error    <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_head     <= 1'b0;
      r_chain_en <= 1'b0;
      if (w_start_go) begin
        r_verify  <= verify_en;
        r_error   <= 1'b0;
        r_err_cnt <= '0;
        r_buf_cnt <= '0;
        r_bit_cnt <= '0;
        r_acc_rem <= CNT_W'(CHAIN_LEN);
      end else if (w_abort_go) begin
        r_buf_cnt <= '0;
        r_bit_cnt <= '0;
        r_acc_rem <= '0;
      end else if (w_busy) begin
        if (w_pass_end) begin
          // buffer and stream are both drained here; arm the verify pass if needed
          r_bit_cnt <= '0;
          r_buf_cnt <= '0;
          r_acc_rem <= ((r_state == ST_LOAD) && r_verify) ? CNT_W'(CHAIN_LEN) : '0;
        end else begin
          if (r_chain_en) begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
          if (w_accept) begin
            r_head     <= s_data[0];
            r_chain_en <= 1'b1;
            r_buf      <= s_data >> 1;
            r_buf_cnt  <= w_word_bits - BC_W'(1);
            r_acc_rem  <= r_acc_rem - CNT_W'(w_word_bits);
          end else if (r_buf_cnt != '0) begin
            r_head     <= r_buf[0];
            r_chain_en <= 1'b1;
            r_buf      <= r_buf >> 1;
            r_buf_cnt  <= r_buf_cnt - BC_W'(1);
          end
        end
        if (w_mismatch) begin
          r_error <= 1'b1;
          if (r_err_cnt != {ERR_W{1'b1}}) begin
            r_err_cnt <= r_err_cnt + ERR_W'(1);
          end
        end
      end
    end
  end

  assign s_ready   = w_ready;
  assign ccff_head = r_head;
  assign chain_en  = r_chain_en;
  assign busy      = w_busy;
  assign done      = (r_state == ST_DONE);
  assign error     = r_error;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader: 16-FF and 12-FF chain models clocked
// on chain_en, checked with immediate assertions against hand-computed values.
module tb_ccff_bitstream_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start16, start12, verify_en, abort, s_valid, force0;
  logic [7:0]  s_data;

  logic        s_ready16, head16, en16, tail16, busy16, done16, error16;
  logic [15:0] errc16;
  logic        s_ready12, head12, en12, tail12, busy12, done12, error12;
  logic [15:0] errc12;

  logic [15:0] chain16 = '0;
  logic [11:0] chain12 = '0;
  logic [31:0] hlog = '0;
  int          en_cnt16 = 0, gap16 = 0, en_cnt12 = 0, en_base16 = 0;
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  ccff_bitstream_loader #(.CHAIN_LEN(16), .DATA_W(8), .ERR_W(16)) dut16 (
    .prog_clk(clk), .pReset(rst_n), .start(start16), .verify_en(verify_en), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready16), .ccff_head(head16),
    .chain_en(en16), .ccff_tail(tail16), .busy(busy16), .done(done16),
    .error(error16), .err_cnt(errc16)
  );

  ccff_bitstream_loader #(.CHAIN_LEN(12), .DATA_W(8), .ERR_W(16)) dut12 (
    .prog_clk(clk), .pReset(rst_n), .start(start12), .verify_en(verify_en), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready12), .ccff_head(head12),
    .chain_en(en12), .ccff_tail(tail12), .busy(busy12), .done(done12),
    .error(error12), .err_cnt(errc12)
  );

  // chain models: new bit enters at the head end, bit 0 is the tail
  assign tail16 = force0 ? 1'b0 : chain16[0];
  assign tail12 = chain12[0];

  always @(posedge clk) begin
    if (en16) chain16 <= {head16, chain16[15:1]};
    if (en12) chain12 <= {head12, chain12[11:1]};
  end

  always @(negedge clk) begin
    if (en16) begin
      en_cnt16 <= en_cnt16 + 1;
      hlog     <= {head16, hlog[31:1]};
    end else if (busy16 && (en_cnt16 != en_base16)) begin
      gap16 <= gap16 + 1;
    end
    if (en12) en_cnt12 <= en_cnt12 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit sel, input bit ve);
    verify_en = ve;
    if (sel) start12 = 1'b1;
    else     start16 = 1'b1;
    tick();
    start12   = 1'b0;
    start16   = 1'b0;
    verify_en = 1'b0;
  endtask

  task automatic send(input bit sel, input logic [7:0] w, input string tag);
    int t;
    t = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (((sel ? s_ready12 : s_ready16) !== 1'b1) && t < 100) begin
      tick();
      t++;
    end
    check(tag, sel ? s_ready12 : s_ready16, 1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input string tag);
    int t;
    t = 0;
    while (((sel ? done12 : done16) !== 1'b1) && t < 300) begin
      tick();
      t++;
    end
    check(tag, sel ? done12 : done16, 1);
  endtask

  initial begin
    int base, g, t, rc;
    rst_n = 1'b0; start16 = 1'b0; start12 = 1'b0; verify_en = 1'b0;
    abort = 1'b0; s_valid = 1'b0; s_data = '0; force0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl16", {s_ready16, head16, en16, busy16, done16, error16}, 0);
    check("rst_errc16", errc16, 0);
    check("rst_ctl12", {s_ready12, head12, en12, busy12, done12, error12, errc12}, 0);
    rst_n = 1'b1;
    tick();

    // plain load, stream never starved
    base = en_cnt16; g = gap16; en_base16 = en_cnt16;
    pulse_start(0, 0);
    send(0, 8'hA5, "t1_rdy0");
    check("t1_latency", {en16, head16}, 2'b11);
    send(0, 8'h3C, "t1_rdy1");
    check("t1_rdy_off", s_ready16, 0);
    wait_done(0, "t1_done");
    check("t1_en_cnt", en_cnt16 - base, 16);
    check("t1_gaps", gap16 - g, 0);
    check("t1_head_seq", hlog[31:16], 16'h3CA5);
    check("t1_chain", chain16, 16'h3CA5);

    // load + verify against a faithful chain
    base = en_cnt16; en_base16 = en_cnt16;
    pulse_start(0, 1);
    send(0, 8'hA5, "t2_w0"); send(0, 8'h3C, "t2_w1");
    send(0, 8'hA5, "t2_w2"); send(0, 8'h3C, "t2_w3");
    wait_done(0, "t2_done");
    check("t2_en_cnt", en_cnt16 - base, 32);
    check("t2_head_seq", hlog, 32'h3CA53CA5);
    check("t2_err", {error16, errc16}, 0);
    check("t2_chain", chain16, 16'h3CA5);

    // tail stuck at 0: every 1 shifted in the verify pass miscompares
    force0 = 1'b1;
    pulse_start(0, 1);
    send(0, 8'hA5, "t3_w0"); send(0, 8'h3C, "t3_w1");
    send(0, 8'hA5, "t3_w2"); send(0, 8'h3C, "t3_w3");
    wait_done(0, "t3_done");
    check("t3_error", error16, 1);
    check("t3_errc", errc16, 8);

    // abort partway through verify: back to idle, error state held
    pulse_start(0, 1);
    send(0, 8'hA5, "t5_w0"); send(0, 8'h3C, "t5_w1"); send(0, 8'hA5, "t5_w2");
    repeat (8) tick();
    check("t5_pre_errc", errc16, 4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_idle", {busy16, en16, s_ready16, done16}, 0);
    tick();
    check("t5_err_held", {error16, errc16}, {1'b1, 16'd4});
    force0 = 1'b0;

    // starved stream: 5 cycles of s_valid low while the loader is ready
    base = en_cnt16; g = gap16; en_base16 = en_cnt16;
    pulse_start(0, 0);
    check("t4_err_clr", {error16, errc16}, 0);
    send(0, 8'hA5, "t4_w0");
    t = 0;
    while (s_ready16 !== 1'b1 && t < 50) begin tick(); t++; end
    repeat (5) tick();
    send(0, 8'h3C, "t4_w1");
    wait_done(0, "t4_done");
    check("t4_en_cnt", en_cnt16 - base, 16);
    check("t4_gaps", gap16 - g, 5);
    check("t4_chain", chain16, 16'h3CA5);

    // reset in the middle of LOAD, then a clean reload
    base = en_cnt16;
    pulse_start(0, 0);
    send(0, 8'hA5, "t6_w0");
    t = 0;
    while ((en_cnt16 - base) < 7 && t < 50) begin tick(); t++; end
    check("t6_en7", en_cnt16 - base, 7);
    rst_n = 1'b0;
    #1;
    check("t6_rst_ctl", {s_ready16, head16, en16, busy16, done16, error16}, 0);
    check("t6_rst_errc", errc16, 0);
    tick();
    rst_n = 1'b1;
    tick();
    base = en_cnt16; en_base16 = en_cnt16;
    pulse_start(0, 0);
    send(0, 8'hA5, "t6_r0"); send(0, 8'h3C, "t6_r1");
    wait_done(0, "t6_done");
    check("t6_en_cnt", en_cnt16 - base, 16);
    check("t6_chain", chain16, 16'h3CA5);

    // 12-bit chain: upper nibble of the second word is dropped
    base = en_cnt12;
    pulse_start(1, 0);
    send(1, 8'hFF, "t7_w0");
    send(1, 8'h0A, "t7_w1");
    s_valid = 1'b1;
    s_data  = 8'h55;
    rc = 0; t = 0;
    while (done12 !== 1'b1 && t < 100) begin
      if (s_ready12) rc++;
      tick();
      t++;
    end
    s_valid = 1'b0;
    check("t7_done", done12, 1);
    check("t7_no_rdy", rc, 0);
    check("t7_en_cnt", en_cnt12 - base, 12);
    check("t7_chain", chain12, 12'hAFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
